bp_lce_noc_mux: RTL and testbench
=================================

Name: bp_lce_noc_mux

Overview:
- N-channel coherence port concentrator between a core's LCEs (I$, D$, and any added accelerator caches) and one coherence-network endpoint.
- Request path: round-robin arbitration of N LCE request channels into a 2-entry output FIFO, gated by a credit counter.
- Command path: demultiplexes one inbound LCE command stream to the N LCEs by destination LCE id.
- Generalises the fixed two-LCE core wiring to num_lce_p channels and adds flow control and error detection.

Parameters:
num_lce_p, 2, number of LCE channels (>=1).
msg_width_p, 128, width of a single-beat request/command message.
lce_id_width_p, 4, LCE id width.
dst_id_lsb_p, 0, LSB position of the destination-LCE-id field in a command message.
credits_p, 8, maximum outstanding requests on the network (>=1).

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous active-low reset
base_lce_id_i  in  lce_id_width_p  LCE id of channel 0; channel k is base+k (static after reset)
lce_req_i  in  num_lce_p*msg_width_p  per-LCE request messages, channel k at slice k
lce_req_v_i  in  num_lce_p  per-LCE request valid
lce_req_ready_o  out  num_lce_p  per-LCE ready; transfer = v&ready
req_o  out  msg_width_p  request to network
req_v_o  out  1  request valid
req_ready_i  in  1  network ready; transfer = v&ready
credit_return_i  in  1  one credit returned this cycle
credits_full_o  out  1  count==credits_p
credits_empty_o  out  1  count==0
cmd_i  in  msg_width_p  inbound command
cmd_v_i  in  1  command valid
cmd_yumi_o  out  1  command consumed this cycle
lce_cmd_o  out  num_lce_p*msg_width_p  per-LCE command (all slices carry cmd_i)
lce_cmd_v_o  out  num_lce_p  per-LCE command valid
lce_cmd_yumi_i  in  num_lce_p  per-LCE consume
bad_dst_o  out  1  sticky: command dropped due to out-of-range destination
credit_err_o  out  1  sticky: credit returned while count==0

Behaviour:
- Reset (reset_n_i==0 at posedge) clears the FIFO, credit count, RR pointer, and both sticky flags. During and after reset: req_v_o=0, lce_req_ready_o=0, credits_empty_o=1, credits_full_o=0, lce_cmd_v_o=0, cmd_yumi_o=0, bad_dst_o=0, credit_err_o=0. Reset mid-transfer discards FIFO contents without emitting them.
- Arbitration (combinational):
  - can_enq = FIFO not full & credits not full.
  - Grant goes to the first valid channel at or after the RR pointer, searching upward with wrap.
  - lce_req_ready_o is one-hot on the granted channel when can_enq; otherwise all zero.
  - On a transfer from channel g, the pointer becomes (g+1) mod num_lce_p. With no transfer, the pointer holds.
- FIFO: 2 entries; req_o/req_v_o driven from the head. Latency from LCE accept to req_v_o is 1 cycle. Simultaneous enqueue and dequeue is allowed when full (no bubble), so full throughput is 1 msg/cycle.
- Credits: width $clog2(credits_p+1).
  - Count increments on enqueue and decrements on credit_return_i.
  - Both in the same cycle: count unchanged.
  - credit_return_i with count==0: count stays 0 and credit_err_o sets.
  - When full, no grants occur; a same-cycle return does not enable a grant until the next cycle (full is taken from the registered count).
- Commands (combinational, no storage):
  - idx = cmd_i[dst_id_lsb_p +: lce_id_width_p] - base_lce_id_i, computed modulo 2^lce_id_width_p.
  - If idx<num_lce_p: lce_cmd_v_o[idx]=cmd_v_i and cmd_yumi_o=lce_cmd_yumi_i[idx].
  - Otherwise: lce_cmd_v_o=0, cmd_yumi_o=cmd_v_i (drop), and bad_dst_o sets on the next edge.
  - lce_cmd_yumi_i on a non-valid channel is ignored.
- All arbitration, FIFO, and credit paths are independent of the command path.

Test Plan:
1. N=2, credits_p=8: both channels held valid continuously with req_ready_i=1 -> grants alternate 0,1,0,1; req_v_o first rises 1 cycle after the first accept; 1 msg/cycle.
2. credits_p=2, req_ready_i=1, no returns: 2 accepts, then credits_full_o=1 and lce_req_ready_o=0; return a credit -> exactly one more accept the following cycle.
3. req_ready_i=0 with credits available: 2 accepts fill the FIFO, lce_req_ready_o drops; raise req_ready_i -> head emitted first (FIFO order preserved), accept and dequeue in the same cycle.
4. base_lce_id_i=4, cmd dst=5 -> lce_cmd_v_o=2'b10; cmd_yumi_o follows lce_cmd_yumi_i[1]. cmd dst=7 -> cmd_yumi_o=1 the same cycle, lce_cmd_v_o=0, bad_dst_o=1 next cycle and sticky.
5. credit_return_i with count 0 -> credit_err_o=1 and count stays 0; enqueue plus return in the same cycle at count 3 -> count stays 3.
6. Assert reset_n_i=0 with the FIFO holding 2 entries -> next cycle req_v_o=0, credits_empty_o=1, RR pointer 0 (channel 0 wins a tie).

Source files
------------

// File: rtl/bp_lce_noc_mux.sv
// Coherence port concentrator: round-robin request arbitration into a credit-gated
// 2-entry FIFO toward the network, plus a destination-decoded command fan-out.
module bp_lce_noc_mux #(
  parameter int num_lce_p      = 2,
  parameter int msg_width_p    = 128,
  parameter int lce_id_width_p = 4,
  parameter int dst_id_lsb_p   = 0,
  parameter int credits_p      = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [lce_id_width_p-1:0]         base_lce_id_i,
  input  logic [num_lce_p*msg_width_p-1:0]  lce_req_i,
  input  logic [num_lce_p-1:0]              lce_req_v_i,
  output logic [num_lce_p-1:0]              lce_req_ready_o,
  output logic [msg_width_p-1:0]            req_o,
  output logic                              req_v_o,
  input  logic                              req_ready_i,
  input  logic                              credit_return_i,
  output logic                              credits_full_o,
  output logic                              credits_empty_o,
  input  logic [msg_width_p-1:0]            cmd_i,
  input  logic                              cmd_v_i,
  output logic                              cmd_yumi_o,
  output logic [num_lce_p*msg_width_p-1:0]  lce_cmd_o,
  output logic [num_lce_p-1:0]              lce_cmd_v_o,
  input  logic [num_lce_p-1:0]              lce_cmd_yumi_i,
  output logic                              bad_dst_o,
  output logic                              credit_err_o
);

  localparam int PW = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;
  localparam int CW = $clog2(credits_p + 1);

  logic [msg_width_p-1:0]    mem_q [2];
  logic [msg_width_p-1:0]    mem_d [2];
  logic                      rd_q, rd_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic [CW-1:0]             cred_q, cred_d;
  logic                      bad_q, bad_d;
  logic                      cerr_q, cerr_d;

  logic                      found;
  logic [PW-1:0]             gnt;
  logic [msg_width_p-1:0]    gnt_msg;
  logic                      cred_full, can_enq, enq, deq;
  logic [lce_id_width_p-1:0] idx;
  logic                      in_range;
  int                        c;

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    c     = 0;
    for (int i = 0; i < num_lce_p; i++) begin
      c = int'(ptr_q) + i;
      if (c >= num_lce_p) c = c - num_lce_p;
      if (!found && lce_req_v_i[c]) begin
        found = 1'b1;
        gnt   = PW'(c);
      end
    end
    gnt_msg = '0;
    for (int k = 0; k < num_lce_p; k++) begin
      if (gnt == PW'(k)) gnt_msg = lce_req_i[k*msg_width_p +: msg_width_p];
    end

    req_v_o   = reset_n_i & (cnt_q != 2'd0);
    req_o     = mem_q[rd_q];
    deq       = req_v_o & req_ready_i;
    cred_full = (cred_q == CW'(credits_p));
    // A full FIFO that is draining this cycle still has room, so no bubble.
    can_enq   = reset_n_i & ((cnt_q != 2'd2) | deq) & ~cred_full;
    enq       = can_enq & found;
    lce_req_ready_o = '0;
    for (int k = 0; k < num_lce_p; k++) begin
      lce_req_ready_o[k] = enq & (gnt == PW'(k));
    end

    credits_full_o  = reset_n_i & cred_full;
    credits_empty_o = ~reset_n_i | (cred_q == '0);

    idx      = cmd_i[dst_id_lsb_p +: lce_id_width_p] - base_lce_id_i;
    in_range = (32'(idx) < num_lce_p);
    lce_cmd_o = {num_lce_p{cmd_i}};
    for (int k = 0; k < num_lce_p; k++) begin
      lce_cmd_v_o[k] = reset_n_i & cmd_v_i & in_range & (32'(idx) == k);
    end
    cmd_yumi_o = (|(lce_cmd_v_o & lce_cmd_yumi_i)) | (reset_n_i & cmd_v_i & ~in_range);

    bad_dst_o    = reset_n_i & bad_q;
    credit_err_o = reset_n_i & cerr_q;
  end

  always_comb begin
    mem_d = mem_q;
    if (enq) mem_d[rd_q ^ cnt_q[0]] = gnt_msg;
    rd_d  = rd_q ^ deq;
    cnt_d = cnt_q + 2'(enq) - 2'(deq);
    ptr_d = ptr_q;
    if (enq) ptr_d = (gnt == PW'(num_lce_p - 1)) ? '0 : gnt + PW'(1);

    cred_d = cred_q;
    cerr_d = cerr_q | (credit_return_i & (cred_q == '0));
    if (enq && !credit_return_i)                          cred_d = cred_q + CW'(1);
    else if (!enq && credit_return_i && cred_q != '0)     cred_d = cred_q - CW'(1);

    bad_d = bad_q | (cmd_v_i & ~in_range);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
      ptr_q  <= '0;
      cred_q <= '0;
      bad_q  <= 1'b0;
      cerr_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      cred_q <= cred_d;
      bad_q  <= bad_d;
      cerr_q <= cerr_d;
    end
  end

endmodule

// File: tb/tb_bp_lce_noc_mux.sv
// Randomized bench for bp_lce_noc_mux: a transaction-level reference model predicts
// every output; emitted requests are checked against a scoreboard queue.
module tb_bp_lce_noc_mux;
  localparam int N = 3, W = 32, IDW = 4, LSB = 4, CP = 3;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic [IDW-1:0]   base_lce_id_i;
  logic [N*W-1:0]   lce_req_i;
  logic [N-1:0]     lce_req_v_i, lce_req_ready_o;
  logic [W-1:0]     req_o;
  logic             req_v_o, req_ready_i, credit_return_i;
  logic             credits_full_o, credits_empty_o;
  logic [W-1:0]     cmd_i;
  logic             cmd_v_i, cmd_yumi_o;
  logic [N*W-1:0]   lce_cmd_o;
  logic [N-1:0]     lce_cmd_v_o, lce_cmd_yumi_i;
  logic             bad_dst_o, credit_err_o;

  always #5 clk_i = ~clk_i;

  bp_lce_noc_mux #(.num_lce_p(N), .msg_width_p(W), .lce_id_width_p(IDW),
                   .dst_id_lsb_p(LSB), .credits_p(CP)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .base_lce_id_i(base_lce_id_i),
    .lce_req_i(lce_req_i), .lce_req_v_i(lce_req_v_i), .lce_req_ready_o(lce_req_ready_o),
    .req_o(req_o), .req_v_o(req_v_o), .req_ready_i(req_ready_i),
    .credit_return_i(credit_return_i), .credits_full_o(credits_full_o),
    .credits_empty_o(credits_empty_o), .cmd_i(cmd_i), .cmd_v_i(cmd_v_i),
    .cmd_yumi_o(cmd_yumi_o), .lce_cmd_o(lce_cmd_o), .lce_cmd_v_o(lce_cmd_v_o),
    .lce_cmd_yumi_i(lce_cmd_yumi_i), .bad_dst_o(bad_dst_o), .credit_err_o(credit_err_o));

  int n_pass = 0, n_tot = 0;
  logic [W-1:0] exp_q[$];
  int m_occ = 0, m_cred = 0, m_ptr = 0;
  bit m_bad = 0, m_err = 0;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    else n_pass++;
  endtask

  // One clock of random stimulus; percentages steer valid/ready/return density.
  task automatic cycle(input int pv, input int pr, input int pt, input bit rst);
    int g, idx;
    bit deq, enq, in_rng;
    logic [N-1:0] ev;
    logic [IDW-1:0] dst;
    @(negedge clk_i);
    reset_n_i = rst;
    for (int k = 0; k < N; k++) begin
      lce_req_v_i[k]      = ($urandom_range(99, 0) < pv);
      lce_req_i[k*W +: W] = $urandom;
    end
    req_ready_i     = ($urandom_range(99, 0) < pr);
    credit_return_i = ($urandom_range(99, 0) < pt);
    cmd_i           = $urandom;
    cmd_v_i         = ($urandom_range(1, 0) == 1);
    lce_cmd_yumi_i  = N'($urandom);
    #1;
    g = -1;
    for (int i = 0; i < N; i++)
      if (g < 0 && lce_req_v_i[(m_ptr + i) % N]) g = (m_ptr + i) % N;
    deq    = rst && m_occ > 0 && req_ready_i;
    enq    = rst && g >= 0 && (m_occ < 2 || deq) && m_cred < CP;
    dst    = cmd_i[LSB +: IDW];
    idx    = (int'(dst) - int'(base_lce_id_i) + 16) % 16;
    in_rng = idx < N;

    ev = '0;
    if (enq) ev[g] = 1'b1;
    chk("lce_req_ready", W'(lce_req_ready_o), W'(ev));
    chk("req_v", W'(req_v_o), W'(rst && m_occ > 0));
    chk("credits_full", W'(credits_full_o), W'(rst && m_cred == CP));
    chk("credits_empty", W'(credits_empty_o), W'(!rst || m_cred == 0));
    ev = '0;
    if (rst && cmd_v_i && in_rng) ev[idx] = 1'b1;
    chk("lce_cmd_v", W'(lce_cmd_v_o), W'(ev));
    chk("cmd_yumi", W'(cmd_yumi_o), W'(rst && cmd_v_i && (in_rng ? lce_cmd_yumi_i[idx] : 1'b1)));
    chk("lce_cmd_data", lce_cmd_o[(N-1)*W +: W], cmd_i);
    chk("bad_dst", W'(bad_dst_o), W'(rst && m_bad));
    chk("credit_err", W'(credit_err_o), W'(rst && m_err));

    if (!rst) begin
      m_occ = 0; m_cred = 0; m_ptr = 0; m_bad = 0; m_err = 0;
      exp_q.delete();
    end else begin
      if (enq) begin
        exp_q.push_back(lce_req_i[g*W +: W]);
        m_ptr = (g + 1) % N;
      end
      m_occ = m_occ + int'(enq) - int'(deq);
      if (credit_return_i && m_cred == 0) m_err = 1;
      if (enq && !credit_return_i) m_cred++;
      else if (!enq && credit_return_i && m_cred > 0) m_cred--;
      if (cmd_v_i && !in_rng) m_bad = 1;
    end
  endtask

  initial forever begin
    @(negedge clk_i);
    #4;
    if (reset_n_i && req_v_o && req_ready_i) begin
      if (exp_q.size() == 0) chk("req_unexpected", W'(1), W'(0));
      else chk("req_data", req_o, exp_q.pop_front());
    end
  end

  initial begin
    reset_n_i = 1'b0; base_lce_id_i = 4'd4; lce_req_i = '0; lce_req_v_i = '0;
    req_ready_i = 1'b0; credit_return_i = 1'b0; cmd_i = '0; cmd_v_i = 1'b0;
    lce_cmd_yumi_i = '0;
    repeat (3)   cycle(0, 0, 0, 1'b0);
    repeat (2)   cycle(0, 100, 100, 1'b1);   // return with no credits out
    repeat (10)  cycle(100, 100, 0, 1'b1);   // credits run out
    repeat (20)  cycle(100, 100, 100, 1'b1); // steady stream
    repeat (400) cycle(50, 50, 40, 1'b1);
    repeat (6)   cycle(100, 0, 50, 1'b1);    // fill the FIFO, then reset over it
    base_lce_id_i = 4'd14;
    repeat (2)   cycle(100, 100, 0, 1'b0);
    repeat (30)  cycle(100, 100, 50, 1'b1);
    repeat (600) cycle(60, 70, 45, 1'b1);
    repeat (5)   cycle(0, 100, 0, 1'b1);
    #5;
    chk("drain_remaining", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
